// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and codes for the camera capture path
//
// Capture FSM states, pixel format codes, decimation codes and the
// decimation-code-to-shift helper shared by the capture modules.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_CAPTURE = 2'd2
  } cam_state_e;

  localparam logic FMT_RGB444 = 1'b0;
  localparam logic FMT_RGB565 = 1'b1;

  localparam logic [1:0] DECIM_1   = 2'd0;
  localparam logic [1:0] DECIM_2   = 2'd1;
  localparam logic [1:0] DECIM_4   = 2'd2;
  localparam logic [1:0] DECIM_1_R = 2'd3;

  // Code 3 is reserved and behaves as 1:1.
  function automatic logic [1:0] decim_shift(input logic [1:0] code);
    case (code)
      DECIM_2: return 2'd1;
      DECIM_4: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cam_pix_unpack.sv
// rtl/cam_pix_unpack.sv - byte pair to 12-bit RGB444 pixel conversion
//
// Purely combinational.
// Ports:
//   i_b1   first byte of the pixel (held)
//   i_b2   second byte of the pixel
//   i_fmt  FMT_RGB444 or FMT_RGB565
//   o_rgb  {R[3:0],G[3:0],B[3:0]}
module cam_pix_unpack
  import cam_pkg::*;
(
  input  logic [7:0]  i_b1,
  input  logic [7:0]  i_b2,
  input  logic        i_fmt,
  output logic [11:0] o_rgb
);

  always_comb begin
    if (i_fmt == FMT_RGB565) begin
      // Keep the top four bits of each 565 channel.
      o_rgb = {i_b1[7:4], i_b1[2:0], i_b2[7], i_b2[4:1]};
    end else begin
      o_rgb = {i_b1[3:0], i_b2[7:4], i_b2[3:0]};
    end
  end

endmodule

// File: rtl/cam_capture_roi.sv
// rtl/cam_capture_roi.sv - camera byte stream to ROI-windowed frame-buffer writes
//
// Pairs camera bytes into pixels, converts them to RGB444 and writes the
// pixels of a programmable, optionally decimated region of interest into a
// linear frame buffer.
// Ports:
//   i_pclk, i_rst              pixel clock, async active-high reset
//   i_vsync, i_href, i_D       camera timing and data byte
//   i_cam_done                 sensor init complete; arms capture
//   i_fmt, i_roi_*, i_decim    frame configuration, latched at frame start
//   o_pix_addr, o_pix_data     frame-buffer write address and pixel
//   o_wr                       write strobe
//   o_frame_done               pulse at end of a captured frame
//   o_ovf                      sticky address-overflow flag
module cam_capture_roi
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 17,
  parameter int SKIP_FRAMES = 2
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_D,
  input  logic              i_cam_done,
  input  logic              i_fmt,
  input  logic [10:0]       i_roi_x0,
  input  logic [10:0]       i_roi_y0,
  input  logic [10:0]       i_roi_w,
  input  logic [10:0]       i_roi_h,
  input  logic [1:0]        i_decim,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [11:0]       o_pix_data,
  output logic              o_wr,
  output logic              o_frame_done,
  output logic              o_ovf
);

  localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);
  // Wide enough for row_base plus any in-line offset without wrapping.
  localparam int EW = (ADDR_W + 2 > 13) ? ADDR_W + 2 : 13;
  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

  cam_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_prev_q, vs_prev_d;
  logic              href_prev_q, href_prev_d;
  logic              fmt_q, fmt_d;
  logic [10:0]       x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [1:0]        shift_q, shift_d;
  logic [10:0]       x_q, x_d, y_q, y_d;
  logic              phase_q, phase_d;
  logic [7:0]        b1_q, b1_d;
  logic [ADDR_W:0]   row_base_q, row_base_d;
  logic              line_hit_q, line_hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       data_q, data_d;
  logic              wr_q, wr_d, done_q, done_d, ovf_q, ovf_d;

  logic              frame_start, frame_end, href_fall, pix_done, start_frame;
  logic [11:0]       x12, y12, x_end, y_end, x_off, y_off, dmask;
  logic              in_roi;
  logic [EW-1:0]     addr_full, rb_next;
  logic              addr_ovf, rb_ovf;
  logic [11:0]       pix_rgb;

  cam_pix_unpack u_unpack (
    .i_b1  (b1_q),
    .i_b2  (i_D),
    .i_fmt (fmt_q),
    .o_rgb (pix_rgb)
  );

  assign frame_start = vs_prev_q & ~vs_s2_q;
  assign frame_end   = ~vs_prev_q & vs_s2_q;
  assign href_fall   = href_prev_q & ~i_href;
  assign pix_done    = i_href & phase_q;

  assign x12   = {1'b0, x_q};
  assign y12   = {1'b0, y_q};
  assign x_end = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end = {1'b0, y0_q} + {1'b0, h_q};
  assign x_off = x12 - {1'b0, x0_q};
  assign y_off = y12 - {1'b0, y0_q};
  assign dmask = (12'd1 << shift_q) - 12'd1;

  // The H/V limits clip any ROI that runs past the active area.
  assign in_roi = (x12 >= {1'b0, x0_q}) && (x12 < x_end) && (x12 < H_LIM) &&
                  (y12 >= {1'b0, y0_q}) && (y12 < y_end) && (y12 < V_LIM) &&
                  ((x_off & dmask) == 12'd0) && ((y_off & dmask) == 12'd0);

  assign addr_full = EW'(row_base_q) + EW'(x_off >> shift_q);
  assign addr_ovf  = |addr_full[EW-1:ADDR_W];
  assign rb_next   = EW'(row_base_q) + EW'(w_q >> shift_q);
  assign rb_ovf    = |rb_next[EW-1:ADDR_W];

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    vs_s1_d     = i_vsync;
    vs_s2_d     = vs_s1_q;
    vs_prev_d   = vs_s2_q;
    href_prev_d = i_href;
    fmt_d       = fmt_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    shift_d     = shift_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = i_href ? ~phase_q : 1'b0;
    b1_d        = (i_href && !phase_q) ? i_D : b1_q;
    row_base_d  = row_base_q;
    line_hit_d  = line_hit_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_d        = 1'b0;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    start_frame = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (i_cam_done) begin
          if (skip_q >= SKIP_W'(SKIP_FRAMES)) begin
            state_d = ST_IDLE;
          end else if (frame_start) begin
            skip_d = skip_q + SKIP_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          state_d     = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (frame_start) begin
          // vsync high was missed: treat as a fresh frame, no done pulse.
          start_frame = 1'b1;
        end else if (frame_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          if (pix_done) begin
            if (x12 < H_LIM) x_d = x_q + 11'd1;
            if (in_roi) begin
              // Suppressed writes still advance the row so later lines
              // keep their true addresses.
              line_hit_d = 1'b1;
              if (addr_ovf) begin
                ovf_d = 1'b1;
              end else begin
                wr_d   = 1'b1;
                addr_d = addr_full[ADDR_W-1:0];
                data_d = pix_rgb;
              end
            end
          end
          if (href_fall) begin
            x_d        = 11'd0;
            line_hit_d = 1'b0;
            if (y12 < V_LIM) y_d = y_q + 11'd1;
            if (line_hit_q) begin
              // Pin row_base at 2^ADDR_W once past the end so it never wraps.
              row_base_d = rb_ovf ? {1'b1, {ADDR_W{1'b0}}} : rb_next[ADDR_W:0];
            end
          end
        end
      end
      default: state_d = ST_WAIT;
    endcase

    if (start_frame) begin
      fmt_d      = i_fmt;
      x0_d       = i_roi_x0;
      y0_d       = i_roi_y0;
      w_d        = i_roi_w;
      h_d        = i_roi_h;
      shift_d    = decim_shift(i_decim);
      x_d        = 11'd0;
      y_d        = 11'd0;
      phase_d    = 1'b0;
      row_base_d = '0;
      line_hit_d = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_WAIT;
      skip_q      <= '0;
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      fmt_q       <= FMT_RGB444;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      shift_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      b1_q        <= '0;
      row_base_q  <= '0;
      line_hit_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      vs_s1_q     <= vs_s1_d;
      vs_s2_q     <= vs_s2_d;
      vs_prev_q   <= vs_prev_d;
      href_prev_q <= href_prev_d;
      fmt_q       <= fmt_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      shift_q     <= shift_d;
      x_q         <= x_d;
      y_q         <= y_d;
      phase_q     <= phase_d;
      b1_q        <= b1_d;
      row_base_q  <= row_base_d;
      line_hit_q  <= line_hit_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_pix_addr   = addr_q;
  assign o_pix_data   = data_q;
  assign o_wr         = wr_q;
  assign o_frame_done = done_q;
  assign o_ovf        = ovf_q;

endmodule

// File: tb/tb_cam_capture_roi.sv
// tb/tb_cam_capture_roi.sv - randomized frame-level bench for cam_capture_roi
module tb_cam_capture_roi;

  localparam int H    = 32;
  localparam int V    = 24;
  localparam int AW   = 9;
  localparam int SKIP = 2;

  logic          clk = 1'b0;
  logic          rst, vsync, href, cam_done, fmt;
  logic [7:0]    d;
  logic [10:0]   x0, y0, w, h;
  logic [1:0]    decim;
  logic [AW-1:0] pix_addr;
  logic [11:0]   pix_data;
  logic          wr, frame_done, ovf;

  cam_capture_roi #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .SKIP_FRAMES(SKIP)
  ) dut (
    .i_pclk(clk), .i_rst(rst), .i_vsync(vsync), .i_href(href), .i_D(d),
    .i_cam_done(cam_done), .i_fmt(fmt), .i_roi_x0(x0), .i_roi_y0(y0),
    .i_roi_w(w), .i_roi_h(h), .i_decim(decim),
    .o_pix_addr(pix_addr), .o_pix_data(pix_data), .o_wr(wr),
    .o_frame_done(frame_done), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;

  int  n_vec = 0;
  int  n_bad = 0;
  wr_t exp_q[$];
  int  f_wr_cnt, f_last_addr, f_first_data, f_second_data;
  int  done_cnt, exp_done;
  bit  force565;
  // Frame-level model state.
  int  skips;
  bit  past_wait, cap, exp_ovf;
  int  m_fmt, m_x0, m_y0, m_w, m_h, m_sh, m_rb;
  bit  m_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  function automatic int unpack(input int f, input int b1, input int b2);
    int r, g, b;
    if (f != 0) begin
      r = b1 / 16;
      g = (b1 % 8) * 2 + b2 / 128;
      b = (b2 / 2) % 16;
    end else begin
      r = b1 % 16;
      g = b2 / 16;
      b = b2 % 16;
    end
    return r * 256 + g * 16 + b;
  endfunction

  // Compare process: every DUT write must be the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (wr) begin
        f_wr_cnt++;
        f_last_addr = int'(pix_addr);
        if (f_wr_cnt == 1) f_first_data = int'(pix_data);
        if (f_wr_cnt == 2) f_second_data = int'(pix_data);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h want no write", pix_addr, pix_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", pix_addr, e.addr);
          check("wr_data", pix_data, e.data);
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_frame_start();
    if (past_wait) begin
      cap = 1; m_fmt = fmt; m_x0 = x0; m_y0 = y0; m_w = w; m_h = h;
      m_sh = (decim == 2'd1) ? 1 : (decim == 2'd2) ? 2 : 0;
      m_rb = 0; m_hit = 0; exp_ovf = 0;
    end else if (cam_done) begin
      skips++;
      if (skips >= SKIP) past_wait = 1;
    end
  endtask

  task automatic model_pixel(input int x, input int y, input int b1, input int b2, output bit pushed);
    int ox, oy, a, step;
    wr_t e;
    pushed = 0;
    if (!cap) return;
    ox = x - m_x0;
    oy = y - m_y0;
    step = 1 << m_sh;
    if (x < H && y < V && ox >= 0 && ox < m_w && oy >= 0 && oy < m_h &&
        ox % step == 0 && oy % step == 0) begin
      m_hit = 1;
      a = m_rb + ox / step;
      if (a >= (1 << AW)) exp_ovf = 1;
      else begin
        e.addr = a;
        e.data = unpack(m_fmt, b1, b2);
        exp_q.push_back(e);
        pushed = 1;
      end
    end
  endtask

  task automatic run_frame(input int f, input int ix0, input int iy0, input int iw, input int ih,
                           input int idec, input int cut_y, input int cut_x,
                           input int rst_y, input int rst_x);
    logic [7:0] b1, b2;
    bit pushed, cut;
    cut = 0;
    vsync = 1; href = 0;
    fmt = f[0]; x0 = ix0[10:0]; y0 = iy0[10:0]; w = iw[10:0]; h = ih[10:0]; decim = idec[1:0];
    tick(4);
    f_wr_cnt = 0; f_last_addr = -1; f_first_data = -1; f_second_data = -1;
    vsync = 0;
    model_frame_start();
    tick(6);
    check("ovf_at_start", ovf, exp_ovf);
    // Config changes mid-frame must not matter.
    fmt = 1'($urandom); x0 = 11'($urandom); y0 = 11'($urandom);
    w = 11'($urandom); h = 11'($urandom); decim = 2'($urandom);
    for (int y = 0; y < V && !cut; y++) begin
      for (int x = 0; x < H && !cut; x++) begin
        b1 = 8'($urandom); b2 = 8'($urandom);
        if (force565 && y == 0 && x == 0) begin b1 = 8'hF8; b2 = 8'h1F; end
        if (force565 && y == 0 && x == 1) begin b1 = 8'h07; b2 = 8'hE0; end
        href = 1; d = b1;
        if (y == cut_y && x == cut_x) vsync = 1;
        tick(1);
        d = b2;
        model_pixel(x, y, b1, b2, pushed);
        tick(1);
        if (y == cut_y && x == cut_x) begin
          if (cap) exp_done++;
          cap = 0; cut = 1;
          repeat (6) begin d = 8'($urandom); tick(1); end
        end
        if (y == rst_y && x == rst_x) begin
          #2;
          check("wr_before_reset", wr, pushed);
          rst = 1;
          #1;
          check("rst_wr", wr, 0);
          check("rst_addr", pix_addr, 0);
          check("rst_data", pix_data, 0);
          check("rst_ovf", ovf, 0);
          exp_q.delete();
          cap = 0; past_wait = 0; skips = 0; exp_ovf = 0;
          @(posedge clk); #1;
          rst = 0;
        end
      end
      href = 0;
      if (!cut) begin
        if (cap && m_hit) m_rb += m_w >> m_sh;
        m_hit = 0;
      end
      tick(4);
    end
    if (!cut) begin
      vsync = 1;
      @(posedge clk); @(negedge clk); check("done_lat1", frame_done, 0);
      @(posedge clk); @(negedge clk); check("done_lat2", frame_done, 0);
      @(posedge clk); @(negedge clk); check("done_lat3", frame_done, cap);
      if (cap) exp_done++;
      cap = 0;
      tick(2);
    end
    check("leftover_writes", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    check("ovf_end", ovf, exp_ovf);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    rst = 1; vsync = 1; href = 0; d = 0; cam_done = 0; fmt = 0;
    x0 = 0; y0 = 0; w = 0; h = 0; decim = 0; force565 = 0;
    skips = 0; past_wait = 0; cap = 0; exp_ovf = 0; exp_done = 0; done_cnt = 0;
    m_hit = 0; m_rb = 0;
    tick(3);
    check("reset_wr", wr, 0);
    check("reset_addr", pix_addr, 0);
    check("reset_data", pix_data, 0);
    check("reset_done", frame_done, 0);
    check("reset_ovf", ovf, 0);
    rst = 0;
    tick(2);

    run_frame(0, 0, 0, H, V, 0, -1, -1, -1, -1);
    check("cam_not_done_writes", f_wr_cnt, 0);
    cam_done = 1;
    run_frame(0, 0, 0, H, V, 0, -1, -1, -1, -1);
    check("skip1_writes", f_wr_cnt, 0);
    run_frame(0, 0, 0, H, V, 0, -1, -1, -1, -1);
    check("skip2_writes", f_wr_cnt, 0);

    run_frame(0, 8, 6, 16, 12, 0, -1, -1, -1, -1);
    check("roi_count", f_wr_cnt, 192);
    check("roi_last_addr", f_last_addr, 191);

    cam_done = 0;
    force565 = 1;
    run_frame(1, 0, 0, 2, 1, 0, -1, -1, -1, -1);
    force565 = 0;
    check("rgb565_count", f_wr_cnt, 2);
    check("rgb565_px0", f_first_data, 32'hF0F);
    check("rgb565_px1", f_second_data, 32'h0F0);

    run_frame(0, 0, 0, H, V, 2, -1, -1, -1, -1);
    check("decim4_count", f_wr_cnt, 48);
    check("decim4_last_addr", f_last_addr, 47);

    run_frame(1, 0, 0, H, V, 0, -1, -1, -1, -1);
    check("ovf_count", f_wr_cnt, 512);
    check("ovf_last_addr", f_last_addr, 511);
    check("ovf_flag", ovf, 1);

    run_frame(0, 4, 4, 8, 8, 1, -1, -1, -1, -1);
    check("ovf_cleared", ovf, 0);
    check("decim2_count", f_wr_cnt, 16);

    run_frame(0, 0, 0, H, V, 0, 5, 10, -1, -1);
    check("cut_count", f_wr_cnt, 171);
    check("cut_last_addr", f_last_addr, 170);

    cam_done = 1;
    run_frame(0, 0, 0, H, V, 0, -1, -1, 3, 5);
    run_frame(0, 0, 0, H, V, 0, -1, -1, -1, -1);
    check("post_rst_skip1", f_wr_cnt, 0);
    run_frame(0, 0, 0, H, V, 0, -1, -1, -1, -1);
    check("post_rst_skip2", f_wr_cnt, 0);
    run_frame(0, 0, 0, 8, 8, 0, -1, -1, -1, -1);
    check("post_rst_count", f_wr_cnt, 64);

    for (int i = 0; i < 6; i++) begin
      int rw, rh;
      rw = (i == 0) ? 0 : int'($urandom_range(1, 40));
      rh = (i == 1) ? 0 : int'($urandom_range(1, 30));
      run_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 30)), rw, rh, int'($urandom_range(0, 3)),
                -1, -1, -1, -1);
      if (i < 2) check("empty_roi_writes", f_wr_cnt, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_capture_roi.md
# cam_capture_roi

Parametrised camera capture front-end for OV7670-class sensors: pairs the 8-bit byte stream into pixels, converts RGB444 or RGB565 input to 12-bit RGB444, and writes only a runtime-programmable region of interest (ROI), optionally decimated by 2 or 4, into a linear frame buffer. Sits between the camera pins (pclk domain) and the frame-buffer write port, replacing the fixed-window capture path.

## Interface

Parameters:
- H_ACTIVE, 640, active pixels per line; x counter saturates here
- V_ACTIVE, 480, active lines per frame; y counter saturates here
- ADDR_W, 17, frame-buffer address width
- SKIP_FRAMES, 2, frame starts discarded after i_cam_done before the first capture

Ports:
- i_pclk  in  1  camera pixel clock; sole clock
- i_rst  in  1  asynchronous, active-high reset
- i_vsync  in  1  camera vsync; high = vertical blanking
- i_href  in  1  camera href; high = valid byte on i_D
- i_D  in  8  camera data byte
- i_cam_done  in  1  sensor register init complete (level)
- i_fmt  in  1  0 = RGB444, 1 = RGB565; latched at frame start
- i_roi_x0, i_roi_y0  in  11 each  ROI origin; latched at frame start
- i_roi_w, i_roi_h  in  11 each  ROI size in source pixels; latched at frame start
- i_decim  in  2  0 = 1:1, 1 = 1:2, 2 = 1:4, 3 = treated as 1:1; latched at frame start
- o_pix_addr  out  ADDR_W  write address
- o_pix_data  out  12  {R[3:0],G[3:0],B[3:0]}
- o_wr  out  1  write strobe, one cycle per stored pixel
- o_frame_done  out  1  one-cycle pulse at end of each captured frame
- o_ovf  out  1  sticky: a write was suppressed because its address exceeded 2^ADDR_W-1; cleared at next captured frame start

## Operation

- vsync: two-flop synchroniser plus edge register; frame start = falling edge, frame end = rising edge.
- States: WAIT -> IDLE after i_cam_done high and SKIP_FRAMES frame starts counted (counter counts only while i_cam_done high). IDLE -> CAPTURE on frame start (latch i_fmt, ROI, i_decim; clear x, y, row_base, byte phase, o_ovf). CAPTURE -> IDLE on frame end, pulsing o_frame_done.
- Byte phase toggles per href-high cycle; forced to 0 while href low (odd byte at line end discarded).
- Unpack (second byte b2, held first byte b1): RGB444: R=b1[3:0], G=b2[7:4], B=b2[3:0]. RGB565: R=b1[7:4], G={b1[2:0],b2[7]}, B=b2[4:1].
- x increments per completed pixel, saturating at H_ACTIVE; y increments on href falling edge, saturating at V_ACTIVE; x clears on href falling edge.
- Pixel stored when x0<=x<x0+w, y0<=y<y0+h, and low i_decim bits of (x-x0) and (y-y0) are zero.
- Address = row_base + ((x-x0)>>decim), no multiplier; row_base += (w>>decim) at the end of every line that stored at least one pixel.
- 12-bit arithmetic for x0+w and y0+h; ROI overrunning H_ACTIVE/V_ACTIVE is clipped naturally.

## Timing

- Reset values: o_pix_addr 0, o_pix_data 0, o_wr 0, o_frame_done 0, o_ovf 0; state WAIT, skip counter 0.
- o_wr, o_pix_addr, o_pix_data registered together, valid the cycle after the second byte is sampled (1-cycle latency).
- o_frame_done asserted 3 pclk after vsync rises (2 sync + 1 edge register).
- vsync rising mid-line: frame ends immediately, partial line kept, no further writes.
- Frame start while in CAPTURE (missed vsync high): re-latch and restart at address 0; no o_frame_done.
- i_cam_done falling: ignored once past WAIT.
- Reset mid-frame: outputs to reset values immediately; skip count restarts.
- ROI inputs changed mid-frame: no effect until next frame start.
- w=0 or h=0: no writes; o_frame_done still pulses.

## Structure

- Shared package cam_pkg: state localparams (WAIT, IDLE, CAPTURE), format codes (FMT_RGB444, FMT_RGB565), decimation codes.
- Sub-module cam_pix_unpack: combinational (b1, b2, fmt) -> 12-bit RGB444; reused by future capture paths.

## Test plan

- RGB444, ROI x0=128,y0=132,w=384,h=216, decim 0, full 640x480 frame -> 82944 writes, addresses 0..82943 contiguous, o_frame_done once.
- RGB565 bytes b1=8'hF8, b2=8'h1F -> o_pix_data 12'hF0F; b1=8'h07,b2=8'hE0 -> 12'h0F0.
- decim 2, ROI 0,0,640,480 -> 160x120 = 19200 writes, last address 19199, every 4th pixel of every 4th line.
- i_cam_done high then 3 frames, SKIP_FRAMES=2 -> no writes in frames 1-2, writes begin in frame 3.
- ROI 0,0,640,480 decim 0 with ADDR_W=17 -> writes stop at address 131071, o_ovf set, cleared at next frame start.
- i_rst pulsed mid-line during CAPTURE -> o_wr 0 same cycle, no writes until 2 further frame starts.
